// File: rtl/sram_node_controller.sv
// sram_node_controller
// Command-side front end for the CRF node-score SRAM. It accepts write, read
// and scan commands over a valid/ready handshake and drives the SRAM control
// pins. It captures the SRAM outData for reads. A scan walks every node and
// returns the maximum signed score together with the index of that node.
//
// Optional feature macro: SRAM_CTRL_ERR_EN
//   defined   : op 2'b11 is answered with an error response (rspErr=1).
//   undefined : op 2'b11 is accepted and silently dropped; rspErr stays 0.
//
// Every output comes directly from a flop. The next value of each output is
// computed from the next state, so the outputs line up with the state register.
module sram_node_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [1:0]            cmdOp,
  input  logic [NODE_BITS-1:0]  cmdIndex,
  input  logic [DATA_WIDTH-1:0] cmdData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic [NODE_BITS-1:0]  rspIndex,
  output logic                  rspErr,
  output logic [DATA_WIDTH-1:0] sramData,
  output logic [NODE_BITS-1:0]  sramIndex,
  output logic                  sramCE,
  output logic                  sramWE,
  input  logic [DATA_WIDTH-1:0] sramOut
);

  localparam int NUM_NODES = 2 ** NODE_BITS;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_SCAN  = 2'b10;

  localparam logic [NODE_BITS-1:0]  IDX_ZERO  = NODE_BITS'(0);
  localparam logic [NODE_BITS-1:0]  IDX_ONE   = NODE_BITS'(1);
  localparam logic [NODE_BITS-1:0]  IDX_LAST  = NODE_BITS'(NUM_NODES - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);
  // Most-negative two's-complement score: any real score ties or beats it.
  localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    SCAN  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  stateNext_s;
  logic [NODE_BITS-1:0]    idx_r;
  logic [NODE_BITS-1:0]    idxNext_s;
  logic [NODE_BITS-1:0]    scanIdx_r;
  logic [NODE_BITS-1:0]    scanIdxNext_s;
  logic [DATA_WIDTH-1:0]   maxVal_r;
  logic [DATA_WIDTH-1:0]   maxValNext_s;
  logic [NODE_BITS-1:0]    maxIdx_r;
  logic [NODE_BITS-1:0]    maxIdxNext_s;

  logic [DATA_WIDTH-1:0]   rspDataNext_s;
  logic [NODE_BITS-1:0]    rspIndexNext_s;
  logic                    rspErrNext_s;
  logic [DATA_WIDTH-1:0]   sramDataNext_s;
  logic [NODE_BITS-1:0]    sramIndexNext_s;

  logic                    accept_s;
  logic                    greater_s;
  logic [DATA_WIDTH-1:0]   bestVal_s;
  logic [NODE_BITS-1:0]    bestIdx_s;

  // Signed score comparison used by the scan. It returns 1 only when the
  // candidate is strictly greater than the best score so far.
  function automatic logic scoreGreater(input logic [DATA_WIDTH-1:0] cand,
                                        input logic [DATA_WIDTH-1:0] best);
    scoreGreater = ($signed(cand) > $signed(best));
  endfunction

  // Running maximum of the scan. Ties keep the earlier, lower node index.
  always_comb begin
    greater_s = scoreGreater(sramOut, maxVal_r);
    if (greater_s) begin
      bestVal_s = sramOut;
      bestIdx_s = scanIdx_r;
    end else begin
      bestVal_s = maxVal_r;
      bestIdx_s = maxIdx_r;
    end
  end

  // Next-state and next-datapath logic. Every target holds its value unless
  // a state below changes it.
  always_comb begin
    stateNext_s     = state_r;
    idxNext_s       = idx_r;
    scanIdxNext_s   = scanIdx_r;
    maxValNext_s    = maxVal_r;
    maxIdxNext_s    = maxIdx_r;
    rspDataNext_s   = rspData;
    rspIndexNext_s  = rspIndex;
    rspErrNext_s    = rspErr;
    sramDataNext_s  = sramData;
    sramIndexNext_s = sramIndex;
    accept_s        = cmdValid & cmdReady;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          idxNext_s = cmdIndex;
          case (cmdOp)
            OP_WRITE: begin
              stateNext_s     = WRITE;
              sramIndexNext_s = cmdIndex;
              sramDataNext_s  = cmdData;
            end
            OP_READ: begin
              stateNext_s     = READ;
              sramIndexNext_s = cmdIndex;
            end
            OP_SCAN: begin
              stateNext_s     = SCAN;
              scanIdxNext_s   = IDX_ZERO;
              maxValNext_s    = MOST_NEG;
              maxIdxNext_s    = IDX_ZERO;
              sramIndexNext_s = IDX_ZERO;
            end
            default: begin
`ifdef SRAM_CTRL_ERR_EN
              // The reserved op returns an error response and does not access the SRAM.
              stateNext_s    = RESP;
              rspErrNext_s   = 1'b1;
              rspDataNext_s  = DATA_ZERO;
              rspIndexNext_s = IDX_ZERO;
`else
              // The reserved op is accepted and dropped with no response.
              stateNext_s    = IDLE;
`endif
            end
          endcase
        end else begin
          stateNext_s = IDLE;
        end
      end

      WRITE: begin
        stateNext_s = IDLE;
      end

      READ: begin
        stateNext_s    = RESP;
        rspDataNext_s  = sramOut;
        rspIndexNext_s = idx_r;
        rspErrNext_s   = 1'b0;
      end

      SCAN: begin
        maxValNext_s = bestVal_s;
        maxIdxNext_s = bestIdx_s;
        if (scanIdx_r == IDX_LAST) begin
          stateNext_s    = RESP;
          rspDataNext_s  = bestVal_s;
          rspIndexNext_s = bestIdx_s;
          rspErrNext_s   = 1'b0;
        end else begin
          stateNext_s     = SCAN;
          scanIdxNext_s   = scanIdx_r + IDX_ONE;
          sramIndexNext_s = scanIdx_r + IDX_ONE;
        end
      end

      RESP: begin
        if (rspReady) begin
          stateNext_s  = IDLE;
          rspErrNext_s = 1'b0;
        end else begin
          stateNext_s = RESP;
        end
      end

      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers. The reset is synchronous and
  // active-low, and it aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r   <= IDLE;
      idx_r     <= IDX_ZERO;
      scanIdx_r <= IDX_ZERO;
      maxVal_r  <= MOST_NEG;
      maxIdx_r  <= IDX_ZERO;
      cmdReady  <= 1'b1;
      rspValid  <= 1'b0;
      rspData   <= DATA_ZERO;
      rspIndex  <= IDX_ZERO;
      rspErr    <= 1'b0;
      sramData  <= DATA_ZERO;
      sramIndex <= IDX_ZERO;
      sramCE    <= 1'b0;
      sramWE    <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      idx_r     <= idxNext_s;
      scanIdx_r <= scanIdxNext_s;
      maxVal_r  <= maxValNext_s;
      maxIdx_r  <= maxIdxNext_s;
      cmdReady  <= (stateNext_s == IDLE);
      rspValid  <= (stateNext_s == RESP);
      rspData   <= rspDataNext_s;
      rspIndex  <= rspIndexNext_s;
      rspErr    <= rspErrNext_s;
      sramData  <= sramDataNext_s;
      sramIndex <= sramIndexNext_s;
      sramCE    <= (stateNext_s == WRITE) || (stateNext_s == READ) || (stateNext_s == SCAN);
      sramWE    <= (stateNext_s == WRITE);
    end
  end

endmodule

// File: tb/tb_sram_node_controller.sv
// tb_sram_node_controller
// Self-checking bench for sram_node_controller. It contains a simple
// asynchronous-read SRAM as the environment. The expected values come from a
// separate reference memory that holds node scores. Its scan result is
// computed directly from the max/argmax rule.
module tb_sram_node_controller;

  localparam int DW = 32;
  localparam int NB = 1;
  localparam int NN = 2 ** NB;

  logic          clk;
  logic          resetN;
  logic          cmdValid;
  logic          cmdReady;
  logic [1:0]    cmdOp;
  logic [NB-1:0] cmdIndex;
  logic [DW-1:0] cmdData;
  logic          rspValid;
  logic          rspReady;
  logic [DW-1:0] rspData;
  logic [NB-1:0] rspIndex;
  logic          rspErr;
  logic [DW-1:0] sramData;
  logic [NB-1:0] sramIndex;
  logic          sramCE;
  logic          sramWE;
  wire  [DW-1:0] sramOut;

  logic [DW-1:0] sramMem [NN];
  logic [DW-1:0] refMem  [NN];

  int errors;
  int checks;

  sram_node_controller #(.DATA_WIDTH(DW), .NODE_BITS(NB)) dut (
    .clk(clk), .resetN(resetN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdIndex(cmdIndex), .cmdData(cmdData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .rspIndex(rspIndex), .rspErr(rspErr),
    .sramData(sramData), .sramIndex(sramIndex), .sramCE(sramCE),
    .sramWE(sramWE), .sramOut(sramOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: a write happens on the clock edge, a read is combinational, and the bus floats when not read.
  always @(posedge clk) if (sramCE && sramWE) sramMem[sramIndex] <= sramData;
  assign sramOut = (sramCE && !sramWE) ? sramMem[sramIndex] : {DW{1'bz}};

  // Reference scan: start from node 0 and replace the best only when a later node is strictly greater.
  function automatic void refScan(output logic [DW-1:0] v, output logic [NB-1:0] ix);
    v  = refMem[0];
    ix = NB'(0);
    for (int n = 1; n < NN; n++) begin
      if ($signed(refMem[n]) > $signed(v)) begin
        v  = refMem[n];
        ix = NB'(n);
      end
    end
  endfunction

  // Present a command at a negedge and wait, with a bound, until it is accepted.
  // On return the bench is at the negedge of the first cycle after the accept.
  task automatic issueCmd(input logic [1:0] op, input logic [NB-1:0] ix, input logic [DW-1:0] d);
    int waitCyc;
    cmdValid = 1'b1; cmdOp = op; cmdIndex = ix; cmdData = d;
    waitCyc = 0;
    while (!cmdReady && waitCyc < 64) begin @(negedge clk); waitCyc++; end
    checks++;
    if (cmdReady !== 1'b1) begin errors++; $display("FAIL cmd_accept_timeout got cmdReady=%b exp=1", cmdReady); end
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  // Wait, with a bound, for a response, capture it and complete the handshake.
  // latency is the number of cycles since the accept, or -1 if the bound expires.
  task automatic getResp(input int start, output logic [DW-1:0] d, output logic [NB-1:0] ix,
                         output logic e, output int latency);
    latency = start;
    while (!rspValid && latency < 64) begin @(negedge clk); latency++; end
    if (!rspValid) latency = -1;
    d = rspData; ix = rspIndex; e = rspErr;
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
  endtask

  // Write feature: exactly one cycle with CE=1 and WE=1 carrying index and data, then idle again.
  task automatic doWrite(input logic [NB-1:0] ix, input logic [DW-1:0] d);
    issueCmd(2'b00, ix, d);
    checks++; if (sramCE !== 1'b1) begin errors++; $display("FAIL wr_ce got=%b exp=1", sramCE); end
    checks++; if (sramWE !== 1'b1) begin errors++; $display("FAIL wr_we got=%b exp=1", sramWE); end
    checks++; if (sramIndex !== ix) begin errors++; $display("FAIL wr_index got=%0d exp=%0d", sramIndex, ix); end
    checks++; if (sramData !== d) begin errors++; $display("FAIL wr_data got=%h exp=%h", sramData, d); end
    checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL wr_busy got=%b exp=0", cmdReady); end
    @(negedge clk);
    checks++; if (sramWE !== 1'b0 || sramCE !== 1'b0) begin errors++; $display("FAIL wr_pulse_end got ce=%b we=%b exp 0 0", sramCE, sramWE); end
    checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL wr_ready_back got=%b exp=1", cmdReady); end
    refMem[ix] = d;
  endtask

  task automatic test_reset();
    resetN = 1'b0; cmdValid = 1'b0; cmdOp = 2'b00; cmdIndex = '0; cmdData = '0; rspReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL rst_cmdReady got=%b exp=1", cmdReady); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rst_rspValid got=%b exp=0", rspValid); end
    checks++; if (sramCE !== 1'b0 || sramWE !== 1'b0) begin errors++; $display("FAIL rst_sram_ctl got ce=%b we=%b exp 0 0", sramCE, sramWE); end
    checks++; if (rspData !== '0 || rspIndex !== '0 || rspErr !== 1'b0) begin errors++; $display("FAIL rst_rsp got data=%h idx=%0d err=%b exp zeros", rspData, rspIndex, rspErr); end
    checks++; if (sramData !== '0 || sramIndex !== '0) begin errors++; $display("FAIL rst_sram_bus got data=%h idx=%0d exp zeros", sramData, sramIndex); end
    resetN = 1'b1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] gd; logic [NB-1:0] gi; logic ge; int lat;
    for (int n = 0; n < NN; n++) doWrite(NB'(n), DW'(32'h1000 + n));
    doWrite(NB'(1), 32'hFFFFFFFF);
    issueCmd(2'b01, NB'(1), 32'h0);
    checks++; if (sramCE !== 1'b1 || sramWE !== 1'b0 || sramIndex !== NB'(1)) begin errors++; $display("FAIL rd_pins got ce=%b we=%b idx=%0d exp 1 0 1", sramCE, sramWE, sramIndex); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rd_early_valid got=%b exp=0", rspValid); end
    getResp(1, gd, gi, ge, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    checks++; if (gd !== refMem[1]) begin errors++; $display("FAIL rd_data got=%h exp=%h", gd, refMem[1]); end
    checks++; if (gi !== NB'(1) || ge !== 1'b0) begin errors++; $display("FAIL rd_idx_err got idx=%0d err=%b exp 1 0", gi, ge); end
    checks++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin errors++; $display("FAIL rd_complete got valid=%b ready=%b exp 0 1", rspValid, cmdReady); end
  endtask

  task automatic test_scan();
    logic [DW-1:0] gd, ed; logic [NB-1:0] gi, ei; logic ge; int lat;
    doWrite(NB'(0), 32'h00000005);
    doWrite(NB'(1), 32'hFFFFFFF0);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) doWrite(NB'(1), 32'h00000005);
      refScan(ed, ei);
      issueCmd(2'b10, NB'(1), 32'h0);
      checks++; if (sramCE !== 1'b1 || sramWE !== 1'b0 || sramIndex !== NB'(0)) begin errors++; $display("FAIL scan_first_node got ce=%b we=%b idx=%0d exp 1 0 0", sramCE, sramWE, sramIndex); end
      @(negedge clk);
      checks++; if (sramCE !== 1'b1 || sramIndex !== NB'(1) || rspValid !== 1'b0) begin errors++; $display("FAIL scan_second_node got ce=%b idx=%0d valid=%b exp 1 1 0", sramCE, sramIndex, rspValid); end
      getResp(2, gd, gi, ge, lat);
      checks++; if (lat !== NN + 1) begin errors++; $display("FAIL scan_latency got=%0d exp=%0d", lat, NN + 1); end
      checks++; if (gd !== ed || gi !== ei) begin errors++; $display("FAIL scan_result pass%0d got %h@%0d exp %h@%0d", pass, gd, gi, ed, ei); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d, gd, ed; logic [NB-1:0] ix, gi, ei; logic ge; int lat; int op;
    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 2));
      ix = NB'($urandom_range(0, NN - 1));
      d  = DW'($urandom);
      if ($urandom_range(0, 3) == 0) d = refMem[$urandom_range(0, NN - 1)];
      case (op)
        0: doWrite(ix, d);
        1: begin
          issueCmd(2'b01, ix, d);
          getResp(1, gd, gi, ge, lat);
          checks++; if (lat !== 2 || gd !== refMem[ix] || gi !== ix) begin errors++; $display("FAIL rand_read it%0d got %h@%0d lat=%0d exp %h@%0d lat=2", it, gd, gi, lat, refMem[ix], ix); end
        end
        default: begin
          refScan(ed, ei);
          issueCmd(2'b10, ix, d);
          getResp(1, gd, gi, ge, lat);
          checks++; if (lat !== NN + 1 || gd !== ed || gi !== ei) begin errors++; $display("FAIL rand_scan it%0d got %h@%0d lat=%0d exp %h@%0d lat=%0d", it, gd, gi, lat, ed, ei, NN + 1); end
        end
      endcase
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    doWrite(NB'(0), 32'hA5A5_0001);
    issueCmd(2'b01, NB'(0), 32'h0);
    @(negedge clk);
    checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise got=%b exp=1", rspValid); end
    held = refMem[0];
    // A write is presented while the response is held back; it must wait.
    cmdValid = 1'b1; cmdOp = 2'b00; cmdIndex = NB'(1); cmdData = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rspValid !== 1'b1 || rspData !== held || rspIndex !== NB'(0)) begin errors++; $display("FAIL bp_hold c%0d got valid=%b data=%h idx=%0d exp 1 %h 0", c, rspValid, rspData, rspIndex, held); end
      checks++; if (cmdReady !== 1'b0 || sramWE !== 1'b0) begin errors++; $display("FAIL bp_busy c%0d got ready=%b we=%b exp 0 0", c, cmdReady, sramWE); end
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checks++; if (rspValid !== 1'b0 || cmdReady !== 1'b1 || sramCE !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b ready=%b ce=%b exp 0 1 0", rspValid, cmdReady, sramCE); end
    @(negedge clk);
    cmdValid = 1'b0;
    checks++; if (sramWE !== 1'b1 || sramIndex !== NB'(1) || sramData !== 32'h1234_5678) begin errors++; $display("FAIL bp_late_write got we=%b idx=%0d data=%h exp 1 1 12345678", sramWE, sramIndex, sramData); end
    refMem[1] = 32'h1234_5678;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    logic [DW-1:0] gd; logic [NB-1:0] gi; logic ge; int lat;
    doWrite(NB'(0), 32'h00000005);
    issueCmd(2'b10, NB'(0), 32'h0);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checks++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin errors++; $display("FAIL mid_rst_handshake got ready=%b valid=%b exp 1 0", cmdReady, rspValid); end
    checks++; if (sramCE !== 1'b0 || sramWE !== 1'b0 || sramIndex !== '0 || sramData !== '0) begin errors++; $display("FAIL mid_rst_sram got ce=%b we=%b idx=%0d data=%h exp zeros", sramCE, sramWE, sramIndex, sramData); end
    checks++; if (rspData !== '0 || rspIndex !== '0 || rspErr !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp got data=%h idx=%0d err=%b exp zeros", rspData, rspIndex, rspErr); end
    repeat (3) @(negedge clk);
    checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped got valid=%b exp=0", rspValid); end
    issueCmd(2'b01, NB'(0), 32'h0);
    getResp(1, gd, gi, ge, lat);
    checks++; if (lat !== 2 || gd !== 32'h00000005 || gi !== NB'(0)) begin errors++; $display("FAIL mid_rst_readback got %h@%0d lat=%0d exp 00000005@0 lat=2", gd, gi, lat); end
  endtask

  task automatic test_reserved();
    logic [DW-1:0] gd; logic [NB-1:0] gi; logic ge; int lat;
    issueCmd(2'b11, NB'(1), 32'hDEAD_BEEF);
    checks++; if (sramCE !== 1'b0 || sramWE !== 1'b0) begin errors++; $display("FAIL rsv_no_access got ce=%b we=%b exp 0 0", sramCE, sramWE); end
`ifdef SRAM_CTRL_ERR_EN
    getResp(1, gd, gi, ge, lat);
    checks++; if (lat !== 1 || ge !== 1'b1 || gd !== '0 || gi !== '0) begin errors++; $display("FAIL rsv_err_rsp got lat=%0d err=%b data=%h idx=%0d exp 1 1 0 0", lat, ge, gd, gi); end
    checks++; if (rspErr !== 1'b0 || rspValid !== 1'b0) begin errors++; $display("FAIL rsv_err_clear got err=%b valid=%b exp 0 0", rspErr, rspValid); end
`else
    checks++; if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin errors++; $display("FAIL rsv_dropped got ready=%b valid=%b exp 1 0", cmdReady, rspValid); end
    repeat (3) @(negedge clk);
    checks++; if (rspValid !== 1'b0 || rspErr !== 1'b0) begin errors++; $display("FAIL rsv_no_rsp got valid=%b err=%b exp 0 0", rspValid, rspErr); end
`endif
    issueCmd(2'b01, NB'(1), 32'h0);
    getResp(1, gd, gi, ge, lat);
    checks++; if (lat !== 2 || gd !== refMem[1] || ge !== 1'b0) begin errors++; $display("FAIL rsv_then_read got %h err=%b lat=%0d exp %h 0 2", gd, ge, lat, refMem[1]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int n = 0; n < NN; n++) refMem[n] = '0;
    test_reset();
    test_write_read();
    test_scan();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
    test_reserved();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
